// File: rtl/perc_var_top_level.sv
// Adaptive perceptual-weighting factor block: computes gamma1/gamma2 for both
// subframes from rc[0..1] and the LSF vectors held in an embedded 4096x32 RAM.
module perc_var_top_level #(
  parameter logic [11:0] LEVINSON_DURBIN_RC    = 12'h040,
  parameter logic [11:0] INTERPOLATION_LSF_INT = 12'h060,
  parameter logic [11:0] INTERPOLATION_LSF_NEW = 12'h080,
  parameter logic [11:0] PERC_VAR_GAMMA1       = 12'h090,
  parameter logic [11:0] PERC_VAR_GAMMA2       = 12'h092
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        percVarMuxSel,
  input  logic        testMemWrite,
  input  logic [31:0] testMemOut,
  input  logic [11:0] testWriteAddr,
  input  logic [11:0] testReadAddr,
  output logic [31:0] memIn,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_RC, S_LAR, S_INTERP, S_SUBFR, S_WRITE, S_DONE
  } state_t;

  // Saturating fixed-point primitives (16-bit words, 32-bit accumulators).
  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)       return 16'sh7fff;
    else if (x < -32'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  function automatic logic signed [15:0] add16(input logic signed [15:0] a, input logic signed [15:0] b);
    return sat16(32'(a) + 32'(b));
  endfunction

  function automatic logic signed [15:0] sub16(input logic signed [15:0] a, input logic signed [15:0] b);
    return sat16(32'(a) - 32'(b));
  endfunction

  function automatic logic signed [15:0] abs16(input logic signed [15:0] a);
    if (a == 16'sh8000) return 16'sh7fff;
    return (a < 16'sd0) ? -a : a;
  endfunction

  function automatic logic signed [15:0] mult16(input logic signed [15:0] a, input logic signed [15:0] b);
    return sat16((32'(a) * 32'(b)) >>> 15);
  endfunction

  function automatic logic signed [31:0] lmult(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (p == 32'sh40000000) return 32'sh7fffffff;
    return p <<< 1;
  endfunction

  function automatic logic signed [31:0] lsub(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    if (d > 33'sh0_7fffffff)      return 32'sh7fffffff;
    else if (d < -33'sh0_80000000) return 32'sh80000000;
    else                          return d[31:0];
  endfunction

  function automatic logic signed [15:0] lar_calc(input logic signed [15:0] rc);
    logic signed [15:0] c, c2, a_k, r;
    logic signed [31:0] b_k;
    c   = abs16(rc) >>> 4;
    c2  = c >>> 1;
    a_k = 16'sd27443;
    b_k = 32'sd46808433;
    if (c <= 16'sd1815) begin
      a_k = 16'sd4567;
      b_k = 32'sd3271557;
    end else if (c <= 16'sd1944) begin
      a_k = 16'sd11776;
      b_k = 32'sd16357786;
    end
    if (c <= 16'sd1299) r = c;
    else                r = 16'(lsub(lmult(c2, a_k), b_k) >>> 11);
    if (rc < 16'sd0) r = sub16(16'sd0, r);
    return r;
  endfunction

  logic [31:0]        mem_q [4096];
  logic [31:0]        mem_rd_q;
  state_t             state_q;
  logic               done_q, smooth_q, k_q;
  logic [3:0]         cnt_q;
  logic signed [15:0] rc0_q, rc1_q, lsf_prev_q, dmin_q;
  logic signed [15:0] lar_new_q [2];
  logic signed [15:0] lar_old_q [2];
  logic signed [15:0] lar_q     [4];
  logic [15:0]        g1_q [2];
  logic [15:0]        g2_q [2];

  logic               fsm_we, mem_we, smooth_d;
  logic [11:0]        fsm_ra, fsm_wa, mem_ra, mem_wa, lsf_base;
  logic [31:0]        fsm_wd, mem_wd;
  logic signed [15:0] lsf_val, diff, dmin_d, la, lb, t, g2_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lsf_base = k_q ? INTERPOLATION_LSF_NEW : INTERPOLATION_LSF_INT;
    fsm_ra   = 12'h000;
    fsm_we   = (state_q == S_WRITE);
    fsm_wa   = PERC_VAR_GAMMA1;
    fsm_wd   = 32'h0;
    case (state_q)
      S_LOAD_RC: fsm_ra = LEVINSON_DURBIN_RC + 12'(cnt_q);
      S_SUBFR:   fsm_ra = lsf_base + 12'(cnt_q);
      default:   fsm_ra = 12'h000;
    endcase
    case (cnt_q[1:0])
      2'd0:    begin fsm_wa = PERC_VAR_GAMMA1;         fsm_wd = {16'h0, g1_q[0]}; end
      2'd1:    begin fsm_wa = PERC_VAR_GAMMA1 + 12'd1; fsm_wd = {16'h0, g1_q[1]}; end
      2'd2:    begin fsm_wa = PERC_VAR_GAMMA2;         fsm_wd = {16'h0, g2_q[0]}; end
      default: begin fsm_wa = PERC_VAR_GAMMA2 + 12'd1; fsm_wd = {16'h0, g2_q[1]}; end
    endcase
    mem_we = percVarMuxSel ? testMemWrite  : fsm_we;
    mem_wa = percVarMuxSel ? testWriteAddr : fsm_wa;
    mem_wd = percVarMuxSel ? testMemOut    : fsm_wd;
    mem_ra = percVarMuxSel ? testReadAddr  : fsm_ra;
  end

  // Running d_min over the LSF stream, then smoothing flag and gamma2 for subframe k.
  always_comb begin
    lsf_val = mem_rd_q[15:0];
    diff    = sub16(lsf_val, lsf_prev_q);
    dmin_d  = ((cnt_q == 4'd2) || (diff < dmin_q)) ? diff : dmin_q;
    la      = k_q ? lar_q[2] : lar_q[0];
    lb      = k_q ? lar_q[3] : lar_q[1];
    if (smooth_q) smooth_d = !((la < -16'sd3562) && (lb > 16'sd1336));
    else          smooth_d = (la > -16'sd3116) || (lb < 16'sd1720);
    t = sat16(32'(add16(mult16(-16'sd6971, dmin_d), 16'sd1114)) <<< 5);
    if (t > 16'sd22938)      g2_d = 16'sd22938;
    else if (t < 16'sd13107) g2_d = 16'sd13107;
    else                     g2_d = t;
  end

  // NOTE: the RAM array has no reset; only the read-data register is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_rd_q <= 32'h0;
    else        mem_rd_q <= mem_q[mem_ra];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      smooth_q     <= 1'b1;
      k_q          <= 1'b0;
      cnt_q        <= 4'd0;
      rc0_q        <= '0;
      rc1_q        <= '0;
      lsf_prev_q   <= '0;
      dmin_q       <= '0;
      lar_new_q    <= '{default: '0};
      lar_old_q    <= '{default: '0};
      lar_q        <= '{default: '0};
      g1_q         <= '{default: '0};
      g2_q         <= '{default: '0};
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          cnt_q <= 4'd0;
          if (start) begin
            state_q <= S_LOAD_RC;
            done_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD_RC: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd1) rc0_q <= mem_rd_q[15:0];
          if (cnt_q == 4'd2) begin
            rc1_q   <= mem_rd_q[15:0];
            state_q <= S_LAR;
          end
        end
        S_LAR: begin
          lar_new_q[0] <= lar_calc(rc0_q);
          lar_new_q[1] <= lar_calc(rc1_q);
          state_q      <= S_INTERP;
        end
        S_INTERP: begin
          lar_q[0]  <= add16(lar_old_q[0], lar_new_q[0]) >>> 1;
          lar_q[1]  <= add16(lar_old_q[1], lar_new_q[1]) >>> 1;
          lar_q[2]  <= lar_new_q[0];
          lar_q[3]  <= lar_new_q[1];
          lar_old_q <= lar_new_q;
          cnt_q     <= 4'd0;
          k_q       <= 1'b0;
          state_q   <= S_SUBFR;
        end
        S_SUBFR: begin
          if (cnt_q >= 4'd1) lsf_prev_q <= lsf_val;
          if (cnt_q >= 4'd2) dmin_q     <= dmin_d;
          if (cnt_q == 4'd10) begin
            smooth_q   <= smooth_d;
            g1_q[k_q]  <= smooth_d ? 16'd30802 : 16'd32113;
            g2_q[k_q]  <= smooth_d ? 16'd19661 : g2_d;
            cnt_q      <= 4'd0;
            k_q        <= 1'b1;
            if (k_q) state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign memIn = mem_rd_q;
  assign done  = done_q;

endmodule

// File: tb/tb_perc_var_top_level.sv
// Directed bench for perc_var_top_level: hand-computed gamma results, test-port
// readback latency, held start, and mid-frame reset recovery.
module tb_perc_var_top_level;

  localparam logic [11:0] RC  = 12'h040;
  localparam logic [11:0] LI  = 12'h060;
  localparam logic [11:0] LN  = 12'h080;
  localparam logic [11:0] G1  = 12'h090;
  localparam logic [11:0] G2  = 12'h092;

  logic        clk = 1'b0;
  logic        reset, start, percVarMuxSel, testMemWrite;
  logic [31:0] testMemOut;
  logic [11:0] testWriteAddr, testReadAddr;
  logic [31:0] memIn;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  perc_var_top_level dut (
    .clk(clk), .reset(reset), .start(start), .percVarMuxSel(percVarMuxSel),
    .testMemWrite(testMemWrite), .testMemOut(testMemOut),
    .testWriteAddr(testWriteAddr), .testReadAddr(testReadAddr),
    .memIn(memIn), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    testWriteAddr = a;
    testMemOut    = d;
    testMemWrite  = 1'b1;
    tick();
    testMemWrite  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    testReadAddr = a;
    tick();
    check(tag, memIn, exp);
  endtask

  task automatic chk_gammas(input string tag, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] b0, input logic [15:0] b1);
    rd_check({tag, "_g1_0"}, G1,         {16'h0, a0});
    rd_check({tag, "_g1_1"}, G1 + 12'd1, {16'h0, a1});
    rd_check({tag, "_g2_0"}, G2,         {16'h0, b0});
    rd_check({tag, "_g2_1"}, G2 + 12'd1, {16'h0, b1});
  endtask

  task automatic write_lsf(input logic [11:0] base, input int first, input int step);
    for (int i = 0; i < 10; i++) wr(base + 12'(i), 32'(first + step * i));
  endtask

  // Start held three cycles; done must drop after the sampling edge, rise within
  // the cycle budget and stay high (no second frame from the held start).
  task automatic run_frame(input string tag);
    int cyc;
    percVarMuxSel = 1'b0;
    start = 1'b1;
    tick();
    check({tag, "_done_fall"}, done, 1'b0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (cyc == 2) start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_within_200"}, done, 1'b1);
    repeat (3) tick();
    check({tag, "_done_held"}, done, 1'b1);
    percVarMuxSel = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; percVarMuxSel = 1'b1; testMemWrite = 1'b0;
    testMemOut = '0; testWriteAddr = '0; testReadAddr = '0;
    repeat (2) tick();
    check("rst_done", done, 1'b0);
    check("rst_memin", memIn, 32'h0);
    reset = 1'b1;
    tick();

    // rc = 0: smoothing stays on, default gammas
    wr(RC, 32'h0); wr(RC + 12'd1, 32'h0);
    run_frame("f0");
    chk_gammas("f0", 16'd30802, 16'd30802, 16'd19661, 16'd19661);

    // fresh reset, strong reflection coefficients
    reset = 1'b0; tick();
    check("rst2_done", done, 1'b0);
    reset = 1'b1; tick();
    wr(RC, 32'hFFFF_8001); wr(RC + 12'd1, 32'h0000_7FFF);
    write_lsf(LN, 1000, 2400);
    run_frame("f1");
    chk_gammas("f1", 16'd30802, 16'd32113, 16'd19661, 16'd19296);

    write_lsf(LI, 1000, 2400);
    run_frame("f2");
    chk_gammas("f2", 16'd32113, 16'd32113, 16'd19296, 16'd19296);

    // spacing 1000 clamps high, spacing 4000 clamps low
    write_lsf(LI, 1000, 1000);
    write_lsf(LN, -16000, 4000);
    run_frame("f3");
    chk_gammas("f3", 16'd32113, 16'd32113, 16'd22938, 16'd13107);

    // test-port write/read of every input and output word
    for (int i = 0; i < 10; i++) wr(RC + 12'(i), {RC + 12'(i), 8'h5A, 12'(i)});
    for (int i = 0; i < 10; i++) wr(LI + 12'(i), {LI + 12'(i), 8'hA5, 12'(i)});
    for (int i = 0; i < 10; i++) wr(LN + 12'(i), {LN + 12'(i), 8'h3C, 12'(i)});
    for (int i = 0; i < 4; i++)  wr(G1 + 12'(i), {G1 + 12'(i), 8'hC3, 12'(i)});
    for (int i = 0; i < 10; i++) rd_check("tp_rc",  RC + 12'(i), {RC + 12'(i), 8'h5A, 12'(i)});
    for (int i = 0; i < 10; i++) rd_check("tp_li",  LI + 12'(i), {LI + 12'(i), 8'hA5, 12'(i)});
    for (int i = 0; i < 10; i++) rd_check("tp_ln",  LN + 12'(i), {LN + 12'(i), 8'h3C, 12'(i)});
    for (int i = 0; i < 4; i++)  rd_check("tp_gam", G1 + 12'(i), {G1 + 12'(i), 8'hC3, 12'(i)});
    // one-cycle read latency: new address not visible before the edge
    testReadAddr = RC;
    #2;
    check("tp_latency_old", memIn, {G1 + 12'd3, 8'hC3, 12'd3});
    tick();
    check("tp_latency_new", memIn, {RC, 8'h5A, 12'd0});

    // abort a frame mid-way with smoothing cleared and lar_old non-zero
    wr(RC, 32'hFFFF_8001); wr(RC + 12'd1, 32'h0000_7FFF);
    write_lsf(LN, 1000, 2400);
    percVarMuxSel = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("abort_done", done, 1'b0);
    check("abort_memin", memIn, 32'h0);
    tick();
    reset = 1'b1;
    percVarMuxSel = 1'b1;
    tick();

    // restored smooth=1 and lar_old=0 reproduce the first strong-rc frame
    run_frame("f4");
    chk_gammas("f4", 16'd30802, 16'd32113, 16'd19661, 16'd19296);

    wr(RC, 32'h0); wr(RC + 12'd1, 32'h0);
    run_frame("f5");
    chk_gammas("f5", 16'd30802, 16'd30802, 16'd19661, 16'd19661);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
